mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single-port unified instruction/data BRAM between the fetch stage and the load/store unit of the 3-stage RISC-V core. Grants at most one access per cycle and routes read data back to the owning requester after the fixed memory latency. Exposes a fetch-stall indication and a starvation guard so that back-to-back stores cannot lock out fetch indefinitely.

Parameters:
XLEN, 32, data/address width of requester ports
ADDR_W, 14, memory word-address width (mem_addr = byte_addr[ADDR_W+1:2])
MEM_LAT, 1, memory read latency in cycles (legal: 1..4)
STARVE_MAX, 3, consecutive data grants tolerated while fetch waits

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request (read only)
if_addr  in  XLEN  fetch byte address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  XLEN  fetch read data
d_req  in  1  data request
d_we  in  4  byte write enables; 4'b0000 = load
d_addr  in  XLEN  data byte address
d_wdata  in  XLEN  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid
d_rdata  out  XLEN  load data
mem_en  out  1  memory enable
mem_we  out  4  memory byte write enables
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  XLEN  memory write data
mem_rdata  in  XLEN  memory read data (MEM_LAT after mem_en)
if_stall  out  1  if_req high and if_gnt low
stall_cnt  out  32  cycles fetch has been stalled (saturating)

Behaviour:
- Reset (reset low, async): tag pipeline invalid, starve_cnt=0, stall_cnt=0; if_rvalid, d_rvalid low; rdata outputs 0. Grant/mem outputs are combinational and resolve to 0 while reset is asserted.
- Requests: requester holds req, addr, we, and wdata stable until gnt. Acceptance = req & gnt in the same cycle. Grants are combinational, zero-cycle.
- Arbitration, each cycle, at most one grant:
  - only one req high -> grant it;
  - both high -> data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - +1 when data is granted while if_req is denied;
  - cleared when fetch is granted or if_req is low;
  - never exceeds STARVE_MAX.
- Memory drive:
  - mem_en = any grant;
  - mem_addr = granted byte address [ADDR_W+1:2]; upper and lower bits are ignored, with no alignment check;
  - mem_we = d_we on a data grant, else 0;
  - mem_wdata = d_wdata (don't-care when not writing).
- Response tracking: MEM_LAT-deep shift register of {valid, owner}. A stage is pushed valid only for reads (fetch, or data with d_we==0); stores push invalid.
  - Stage MEM_LAT-1 valid & owner=fetch -> if_rvalid=1, if_rdata=mem_rdata.
  - Stage MEM_LAT-1 valid & owner=data -> d_rvalid=1, d_rdata=mem_rdata.
  - Read-data outputs are combinational from mem_rdata. They are 0 when the corresponding rvalid is low.
- Latency: a read accepted in cycle N returns rvalid in cycle N+MEM_LAT. The pipeline is fully pipelined, so a new grant is allowed every cycle independent of in-flight reads.
- Simultaneous events: a response and a new grant in the same cycle are both legal. Responses arrive in order.
- if_stall = if_req & ~if_gnt.
- stall_cnt increments on each if_stall cycle and saturates at 32'hFFFFFFFF.
- Reset mid-operation: in-flight reads are dropped and no rvalid is ever produced for them.

Decomposition:
- Shared package/defines file:
  - owner encoding (OWN_IF=1'b0, OWN_D=1'b1);
  - byte-enable constants (WE_NONE, WE_WORD);
  - `XLEN (already global).
- One sub-module, resp_tag_pipe: parameterised MEM_LAT shift register of {valid, owner}, with async active-low reset.
- Arbitration and starvation logic stay in mem_arbiter.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100 for 3 cycles, MEM_LAT=1 -> if_gnt=1 each cycle, mem_addr=0x40. if_rvalid follows one cycle after each grant, with if_rdata = model memory word.
- Contention: if_req=1 and d_req=1 with d_we=0, d_addr=0x2004 -> d_gnt=1, if_gnt=0, if_stall=1, mem_addr=0x801. Next cycle d_req=0 -> if_gnt=1. Exactly one d_rvalid then one if_rvalid, never both in the same cycle.
- Starvation: d_req held high with d_we=4'hF for 10 cycles, if_req high -> 3 data grants, then 1 fetch grant, repeating. stall_cnt=3 after the first fetch grant.
- Store produces no response: d_we=4'b0011, d_wdata=0xDEADBEEF, d_addr=0x10 -> mem_we=4'b0011, mem_addr=0x4. d_rvalid stays 0 for MEM_LAT+2 cycles.
- MEM_LAT=3 back-to-back: alternating fetch/load grants on 4 consecutive cycles -> rvalids appear on cycles N+3..N+6 in the same owner order, with correct data.
- Reset mid-flight: MEM_LAT=2, load accepted at cycle N, reset low at N+1 for one cycle -> d_rvalid never asserts, and stall_cnt and starve_cnt read 0 after reset.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data BRAM arbiter: requester owner
// encoding, byte-enable constants and a small helper.
package mem_arbiter_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   localparam logic [3:0] WE_NONE = 4'b0000;
   localparam logic [3:0] WE_WORD = 4'b1111;

   // A data access with no byte enables is a load and expects a response.
   function automatic logic is_read(input logic [3:0] we);
      return (we == WE_NONE);
   endfunction

endpackage

// File: rtl/mem_arbiter_resp_tag_pipe.sv
// Tracks outstanding memory accesses: one {valid, owner} tag per cycle of
// memory latency, so read data can be routed back to whoever issued it.
module resp_tag_pipe
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   push_valid,
   input  owner_e push_owner,
   output logic   out_valid,
   output owner_e out_owner
);

   logic [MEM_LAT-1:0] valid_r;
   logic [MEM_LAT-1:0] owner_r;

   // Shift tags one stage per cycle; reset drops every in-flight read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r <= '0;
         owner_r <= '0;
      end else begin
         valid_r[0] <= push_valid;
         owner_r[0] <= push_owner;
         for (int i = 1; i < MEM_LAT; i++) begin
            valid_r[i] <= valid_r[i-1];
            owner_r[i] <= owner_r[i-1];
         end
      end
   end

   assign out_valid = valid_r[MEM_LAT-1];
   assign out_owner = owner_e'(owner_r[MEM_LAT-1]);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port BRAM arbiter between fetch and load/store: zero-cycle grants,
// data priority with a fetch starvation guard, in-order response routing.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ADDR_W     = 14,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [XLEN-1:0]   if_rdata,
   input  logic              d_req,
   input  logic [3:0]        d_we,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [XLEN-1:0]   d_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              if_stall,
   output logic [31:0]       stall_cnt
);

   localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
   localparam logic [SC_W-1:0] STARVE_ONE = SC_W'(1);

   logic [SC_W-1:0] starve_cnt_r;
   logic [31:0]     stall_cnt_r;
   logic            starve_hit_s;
   logic            if_gnt_s;
   logic            d_gnt_s;
   logic            push_valid_s;
   owner_e          push_owner_s;
   logic            tag_valid_s;
   owner_e          tag_owner_s;
   logic            unused_addr_s;

   // Data normally wins; fetch wins once it has lost STARVE_MAX times in a row.
   assign starve_hit_s = (starve_cnt_r == STARVE_LIM);
   assign d_gnt_s      = reset & d_req & ~(if_req & starve_hit_s);
   assign if_gnt_s     = reset & if_req & ~d_gnt_s;

   assign if_gnt   = if_gnt_s;
   assign d_gnt    = d_gnt_s;
   assign if_stall = if_req & ~if_gnt_s;
   assign stall_cnt = stall_cnt_r;

   // Drive the memory port from whichever requester holds the grant.
   always_comb begin
      mem_en    = if_gnt_s | d_gnt_s;
      mem_we    = WE_NONE;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt_s) begin
         mem_we    = d_we;
         mem_addr  = d_addr[ADDR_W+1:2];
         mem_wdata = d_wdata;
      end else if (if_gnt_s) begin
         mem_addr  = if_addr[ADDR_W+1:2];
      end else begin
         mem_addr  = '0;
      end
   end

   assign unused_addr_s = ^{if_addr[XLEN-1:ADDR_W+2], if_addr[1:0],
                            d_addr[XLEN-1:ADDR_W+2], d_addr[1:0]};

   // Stores occupy the port but push an invalid tag: they never respond.
   assign push_valid_s = if_gnt_s | (d_gnt_s & is_read(d_we));
   assign push_owner_s = d_gnt_s ? OWN_D : OWN_IF;

   resp_tag_pipe #(
      .MEM_LAT (MEM_LAT)
   ) u_tag_pipe (
      .clk        (clk),
      .reset      (reset),
      .push_valid (push_valid_s),
      .push_owner (push_owner_s),
      .out_valid  (tag_valid_s),
      .out_owner  (tag_owner_s)
   );

   assign if_rvalid = tag_valid_s & (tag_owner_s == OWN_IF);
   assign d_rvalid  = tag_valid_s & (tag_owner_s == OWN_D);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid  ? mem_rdata : '0;

   // Count consecutive data wins over a waiting fetch; any fetch win or idle fetch clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt_r <= '0;
      end else if (if_gnt_s || !if_req) begin
         starve_cnt_r <= '0;
      end else if (d_gnt_s && !starve_hit_s) begin
         starve_cnt_r <= starve_cnt_r + STARVE_ONE;
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   // Saturating count of fetch stall cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_r <= 32'h0000_0000;
      end else if (if_stall && (stall_cnt_r != 32'hFFFF_FFFF)) begin
         stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (MEM_LAT = 1, 2, 3) share one stimulus stream,
// each fed by its own latency-matched model BRAM.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        d_req;
   logic [3:0]  d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;

   logic        if_gnt_a    [1:3];
   logic        if_rvalid_a [1:3];
   logic [31:0] if_rdata_a  [1:3];
   logic        d_gnt_a     [1:3];
   logic        d_rvalid_a  [1:3];
   logic [31:0] d_rdata_a   [1:3];
   logic        mem_en_a    [1:3];
   logic [3:0]  mem_we_a    [1:3];
   logic [13:0] mem_addr_a  [1:3];
   logic [31:0] mem_wdata_a [1:3];
   logic [31:0] mem_rdata_a [1:3];
   logic        if_stall_a  [1:3];
   logic [31:0] stall_cnt_a [1:3];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Model BRAM contents: each word holds a tag plus its own word address.
   function automatic logic [31:0] model_word(input logic [13:0] a);
      return 32'h5A00_0000 | {18'd0, a};
   endfunction

   for (genvar g = 1; g <= 3; g++) begin : gen_dut
      logic [13:0] hist [g];

      always @(posedge clk) begin
         hist[0] <= mem_addr_a[g];
         for (int i = 1; i < g; i++) hist[i] <= hist[i-1];
      end
      assign mem_rdata_a[g] = model_word(hist[g-1]);

      mem_arbiter #(.XLEN(32), .ADDR_W(14), .MEM_LAT(g), .STARVE_MAX(3)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .if_req    (if_req),
         .if_addr   (if_addr),
         .if_gnt    (if_gnt_a[g]),
         .if_rvalid (if_rvalid_a[g]),
         .if_rdata  (if_rdata_a[g]),
         .d_req     (d_req),
         .d_we      (d_we),
         .d_addr    (d_addr),
         .d_wdata   (d_wdata),
         .d_gnt     (d_gnt_a[g]),
         .d_rvalid  (d_rvalid_a[g]),
         .d_rdata   (d_rdata_a[g]),
         .mem_en    (mem_en_a[g]),
         .mem_we    (mem_we_a[g]),
         .mem_addr  (mem_addr_a[g]),
         .mem_wdata (mem_wdata_a[g]),
         .mem_rdata (mem_rdata_a[g]),
         .if_stall  (if_stall_a[g]),
         .stall_cnt (stall_cnt_a[g])
      );
   end

   task automatic idle_inputs();
      if_req  = 1'b0;
      if_addr = 32'h0;
      d_req   = 1'b0;
      d_we    = 4'h0;
      d_addr  = 32'h0;
      d_wdata = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h100;
      d_req   = 1'b1;
      d_we    = 4'h0;
      d_addr  = 32'h2004;
      d_wdata = 32'h0;
      @(negedge clk);
      @(negedge clk);
      #1;
      for (int g = 1; g <= 3; g++) begin
         n_vec++; if (if_gnt_a[g] !== 1'b0) begin n_err++; $display("FAIL reset_if_gnt[%0d]: got %b expected 0", g, if_gnt_a[g]); end
         n_vec++; if (d_gnt_a[g] !== 1'b0) begin n_err++; $display("FAIL reset_d_gnt[%0d]: got %b expected 0", g, d_gnt_a[g]); end
         n_vec++; if (mem_en_a[g] !== 1'b0) begin n_err++; $display("FAIL reset_mem_en[%0d]: got %b expected 0", g, mem_en_a[g]); end
         n_vec++; if (mem_addr_a[g] !== 14'h0) begin n_err++; $display("FAIL reset_mem_addr[%0d]: got %h expected 0", g, mem_addr_a[g]); end
         n_vec++; if ({if_rvalid_a[g], d_rvalid_a[g]} !== 2'b00) begin n_err++; $display("FAIL reset_rvalid[%0d]: got %b expected 00", g, {if_rvalid_a[g], d_rvalid_a[g]}); end
         n_vec++; if ((if_rdata_a[g] | d_rdata_a[g]) !== 32'h0) begin n_err++; $display("FAIL reset_rdata[%0d]: got %h/%h expected 0", g, if_rdata_a[g], d_rdata_a[g]); end
         n_vec++; if (stall_cnt_a[g] !== 32'h0) begin n_err++; $display("FAIL reset_stall_cnt[%0d]: got %0d expected 0", g, stall_cnt_a[g]); end
      end
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
   endtask

   task automatic test_fetch_only();
      logic exp_rv;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if_req  = (k < 3);
         if_addr = 32'h100;
         d_req   = 1'b0;
         #1;
         if (k < 3) begin
            n_vec++; if (if_gnt_a[1] !== 1'b1) begin n_err++; $display("FAIL fetch_gnt c%0d: got %b expected 1", k, if_gnt_a[1]); end
            n_vec++; if (mem_addr_a[1] !== 14'h040) begin n_err++; $display("FAIL fetch_mem_addr c%0d: got %h expected 040", k, mem_addr_a[1]); end
            n_vec++; if ({mem_en_a[1], mem_we_a[1]} !== 5'b1_0000) begin n_err++; $display("FAIL fetch_mem_en_we c%0d: got %b expected 10000", k, {mem_en_a[1], mem_we_a[1]}); end
            n_vec++; if (if_stall_a[1] !== 1'b0) begin n_err++; $display("FAIL fetch_stall c%0d: got %b expected 0", k, if_stall_a[1]); end
         end
         exp_rv = (k >= 1) && (k <= 3);
         n_vec++; if (if_rvalid_a[1] !== exp_rv) begin n_err++; $display("FAIL fetch_rvalid c%0d: got %b expected %b", k, if_rvalid_a[1], exp_rv); end
         if (exp_rv) begin
            n_vec++; if (if_rdata_a[1] !== 32'h5A00_0040) begin n_err++; $display("FAIL fetch_rdata c%0d: got %h expected 5a000040", k, if_rdata_a[1]); end
         end
      end
   endtask

   task automatic test_contention();
      do_reset();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      d_req = 1'b1; d_we = 4'h0; d_addr = 32'h2004;
      #1;
      n_vec++; if ({d_gnt_a[1], if_gnt_a[1], if_stall_a[1]} !== 3'b101) begin n_err++; $display("FAIL cont_grants: got d/if/stall %b expected 101", {d_gnt_a[1], if_gnt_a[1], if_stall_a[1]}); end
      n_vec++; if (mem_addr_a[1] !== 14'h0801) begin n_err++; $display("FAIL cont_mem_addr: got %h expected 0801", mem_addr_a[1]); end
      @(negedge clk);
      d_req = 1'b0;
      #1;
      n_vec++; if ({d_gnt_a[1], if_gnt_a[1]} !== 2'b01) begin n_err++; $display("FAIL cont_fetch_gnt: got d/if %b expected 01", {d_gnt_a[1], if_gnt_a[1]}); end
      n_vec++; if ({d_rvalid_a[1], if_rvalid_a[1]} !== 2'b10) begin n_err++; $display("FAIL cont_resp1: got d/if rvalid %b expected 10", {d_rvalid_a[1], if_rvalid_a[1]}); end
      n_vec++; if (d_rdata_a[1] !== 32'h5A00_0801) begin n_err++; $display("FAIL cont_d_rdata: got %h expected 5a000801", d_rdata_a[1]); end
      n_vec++; if (stall_cnt_a[1] !== 32'd1) begin n_err++; $display("FAIL cont_stall_cnt: got %0d expected 1", stall_cnt_a[1]); end
      @(negedge clk);
      if_req = 1'b0;
      #1;
      n_vec++; if ({d_rvalid_a[1], if_rvalid_a[1]} !== 2'b01) begin n_err++; $display("FAIL cont_resp2: got d/if rvalid %b expected 01", {d_rvalid_a[1], if_rvalid_a[1]}); end
      n_vec++; if (if_rdata_a[1] !== 32'h5A00_0040) begin n_err++; $display("FAIL cont_if_rdata: got %h expected 5a000040", if_rdata_a[1]); end
      @(negedge clk);
      #1;
      n_vec++; if ({d_rvalid_a[1], if_rvalid_a[1]} !== 2'b00) begin n_err++; $display("FAIL cont_resp3: got d/if rvalid %b expected 00", {d_rvalid_a[1], if_rvalid_a[1]}); end
   endtask

   task automatic test_starvation();
      logic        exp_d;
      logic [31:0] exp_stall;
      do_reset();
      exp_stall = 32'd0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if_req = 1'b1; if_addr = 32'h100;
         d_req = 1'b1; d_we = 4'hF; d_addr = 32'h20; d_wdata = 32'h1234_5678;
         #1;
         exp_d = ((k % 4) != 3);
         n_vec++; if ({d_gnt_a[1], if_gnt_a[1]} !== {exp_d, ~exp_d}) begin n_err++; $display("FAIL starve_grant c%0d: got d/if %b expected %b", k, {d_gnt_a[1], if_gnt_a[1]}, {exp_d, ~exp_d}); end
         n_vec++; if (stall_cnt_a[1] !== exp_stall) begin n_err++; $display("FAIL starve_stall_cnt c%0d: got %0d expected %0d", k, stall_cnt_a[1], exp_stall); end
         n_vec++; if (mem_we_a[1] !== (exp_d ? 4'hF : 4'h0)) begin n_err++; $display("FAIL starve_mem_we c%0d: got %h expected %h", k, mem_we_a[1], (exp_d ? 4'hF : 4'h0)); end
         n_vec++; if (d_rvalid_a[1] !== 1'b0) begin n_err++; $display("FAIL starve_d_rvalid c%0d: got %b expected 0", k, d_rvalid_a[1]); end
         if (exp_d) exp_stall = exp_stall + 32'd1;
      end
   endtask

   task automatic test_store_no_resp();
      do_reset();
      @(negedge clk);
      d_req = 1'b1; d_we = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h10;
      #1;
      n_vec++; if (d_gnt_a[1] !== 1'b1) begin n_err++; $display("FAIL store_gnt: got %b expected 1", d_gnt_a[1]); end
      n_vec++; if (mem_we_a[1] !== 4'b0011) begin n_err++; $display("FAIL store_mem_we: got %b expected 0011", mem_we_a[1]); end
      n_vec++; if (mem_addr_a[1] !== 14'h0004) begin n_err++; $display("FAIL store_mem_addr: got %h expected 0004", mem_addr_a[1]); end
      n_vec++; if (mem_wdata_a[1] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_mem_wdata: got %h expected deadbeef", mem_wdata_a[1]); end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         for (int g = 1; g <= 3; g++) begin
            n_vec++; if (d_rvalid_a[g] !== 1'b0) begin n_err++; $display("FAIL store_d_rvalid[%0d] c%0d: got %b expected 0", g, k, d_rvalid_a[g]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic        exp_if [0:7];
      logic        exp_dv [0:7];
      logic [31:0] exp_dat [0:7];
      do_reset();
      exp_if  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_dv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_dat = '{32'h0, 32'h0, 32'h0, 32'h5A00_0040, 32'h5A00_0801, 32'h5A00_0080, 32'h5A00_0C02, 32'h0};
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         idle_inputs();
         case (k)
            0: begin if_req = 1'b1; if_addr = 32'h100; end
            1: begin d_req = 1'b1; d_addr = 32'h2004; end
            2: begin if_req = 1'b1; if_addr = 32'h200; end
            3: begin d_req = 1'b1; d_addr = 32'h3008; end
            default: ;
         endcase
         #1;
         if (k < 4) begin
            n_vec++; if (mem_en_a[3] !== 1'b1) begin n_err++; $display("FAIL b2b_mem_en c%0d: got %b expected 1", k, mem_en_a[3]); end
         end
         n_vec++; if ({if_rvalid_a[3], d_rvalid_a[3]} !== {exp_if[k], exp_dv[k]}) begin n_err++; $display("FAIL b2b_rvalid c%0d: got if/d %b expected %b", k, {if_rvalid_a[3], d_rvalid_a[3]}, {exp_if[k], exp_dv[k]}); end
         n_vec++; if ((if_rdata_a[3] | d_rdata_a[3]) !== exp_dat[k]) begin n_err++; $display("FAIL b2b_rdata c%0d: got %h expected %h", k, (if_rdata_a[3] | d_rdata_a[3]), exp_dat[k]); end
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h100;
      d_req = 1'b1; d_we = 4'h0; d_addr = 32'h2004;
      #1;
      n_vec++; if (d_gnt_a[2] !== 1'b1) begin n_err++; $display("FAIL mid_load_gnt: got %b expected 1", d_gnt_a[2]); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++; if (stall_cnt_a[2] !== 32'd1) begin n_err++; $display("FAIL mid_stall_pre: got %0d expected 1", stall_cnt_a[2]); end
      n_vec++; if (gen_dut[2].u_dut.starve_cnt_r !== 2'd1) begin n_err++; $display("FAIL mid_starve_pre: got %0d expected 1", gen_dut[2].u_dut.starve_cnt_r); end
      n_vec++; if (d_rvalid_a[2] !== 1'b0) begin n_err++; $display("FAIL mid_d_rvalid_pre: got %b expected 0", d_rvalid_a[2]); end
      reset = 1'b0;
      #1;
      n_vec++; if (stall_cnt_a[2] !== 32'd0) begin n_err++; $display("FAIL mid_stall_post: got %0d expected 0", stall_cnt_a[2]); end
      n_vec++; if (gen_dut[2].u_dut.starve_cnt_r !== 2'd0) begin n_err++; $display("FAIL mid_starve_post: got %0d expected 0", gen_dut[2].u_dut.starve_cnt_r); end
      @(negedge clk);
      reset = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         #1;
         n_vec++; if ({d_rvalid_a[2], if_rvalid_a[2]} !== 2'b00) begin n_err++; $display("FAIL mid_rvalid c%0d: got d/if %b expected 00", k, {d_rvalid_a[2], if_rvalid_a[2]}); end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_fetch_only();
      test_contention();
      test_starvation();
      test_store_no_resp();
      test_back_to_back();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
